// File: rtl/dac_sample_buf_pkg.sv
// Shared constants for the DAC sample buffer and the DAC serialiser that reads it.
// Lane indices name the byte positions inside one stereo frame {right, left}.
package dac_sample_buf_pkg;

  localparam int DEF_AW_A = 11;
  localparam int DEF_DW_A = 8;
  localparam int DEF_AW_B = DEF_AW_A - 2;
  localparam int DEF_DW_B = 4 * DEF_DW_A;

  localparam int NUM_LANES     = 4;
  localparam int LANE_LEFT_LO  = 0;
  localparam int LANE_LEFT_HI  = 1;
  localparam int LANE_RIGHT_LO = 2;
  localparam int LANE_RIGHT_HI = 3;

endpackage

// File: rtl/dac_buf_lane.sv
// One byte lane of the sample buffer: simple dual-port RAM with synchronous write
// and a registered, read-first output that is cleared asynchronously by reset.
module dac_buf_lane #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Reset deliberately leaves the array alone so samples survive a DAC restart.
  always_ff @(posedge clkin) begin
    if (we) begin
      mem[waddr] <= din;
    end
  end

  // The non-blocking update means a same-edge write is seen only on the next read.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else begin
      dout <= mem[raddr];
    end
  end

endmodule

// File: rtl/dac_sample_buf.sv
// Asymmetric sample RAM: byte-wide writes from the MCU bus, 32-bit stereo frame
// reads for the DAC serialiser, built from four little-endian byte lanes.
module dac_sample_buf
  import dac_sample_buf_pkg::*;
#(
  parameter int AW_A = DEF_AW_A,
  parameter int DW_A = DEF_DW_A,
  parameter int AW_B = DEF_AW_B,
  parameter int DW_B = DEF_DW_B
) (
  input  logic            clkin,
  input  logic            reset,
  input  logic            wea,
  input  logic [AW_A-1:0] addra,
  input  logic [DW_A-1:0] dina,
  input  logic [AW_B-1:0] addrb,
  output logic [DW_B-1:0] doutb
);

  logic [AW_B-1:0] word_addr;
  logic [1:0]      lane_sel;

  assign word_addr = addra[AW_A-1:2];
  assign lane_sel  = addra[1:0];

  // Lane i owns doutb[8i +: 8]; lane 0 is the low byte of the left sample.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dac_buf_lane #(
      .AW(AW_B),
      .DW(DW_A)
    ) u_lane (
      .clkin(clkin),
      .reset(reset),
      .we   (wea && (lane_sel == 2'(i))),
      .waddr(word_addr),
      .din  (dina),
      .raddr(addrb),
      .dout (doutb[i*DW_A +: DW_A])
    );
  end

endmodule

// File: tb/tb_dac_sample_buf.sv
// Self-checking bench for dac_sample_buf: directed cases plus a random phase, all
// compared against a byte-array model of the buffer.
module tb_dac_sample_buf;

  logic        clkin;
  logic        reset;
  logic        wea;
  logic [10:0] addra;
  logic [7:0]  dina;
  logic [8:0]  addrb;
  logic [31:0] doutb;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0]  modelMem [0:2047];
  logic [31:0] expDout;

  dac_sample_buf dut (
    .clkin(clkin),
    .reset(reset),
    .wea  (wea),
    .addra(addra),
    .dina (dina),
    .addrb(addrb),
    .doutb(doutb)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  function automatic logic [31:0] frameOf(input int w);
    return {modelMem[4*w+3], modelMem[4*w+2], modelMem[4*w+1], modelMem[4*w]};
  endfunction

  // Reference model: read the addressed frame before applying the byte write.
  always @(posedge clkin) begin
    if (!reset) expDout = frameOf(int'(addrb));
    if (wea) modelMem[addra] = dina;
  end

  always @(posedge reset) expDout = 32'h0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: doutb=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after a falling edge, then check at the next one.
  task automatic applyStimulus(input logic we, input logic [10:0] a, input logic [7:0] d,
                               input logic [8:0] b);
    wea   = we;
    addra = a;
    dina  = d;
    addrb = b;
    @(negedge clkin);
    checkOutput("model", doutb, expDout);
  endtask

  initial begin
    logic [10:0] ra;
    logic [8:0]  rb;
    for (int i = 0; i < 2048; i++) modelMem[i] = 8'h00;
    expDout = 32'h0;
    wea = 1'b0; addra = '0; dina = '0; addrb = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    @(negedge clkin);
    checkOutput("resetState", doutb, 32'h0);

    // Clear the whole array while reset is held; writes must still land.
    for (int i = 0; i < 2048; i++) applyStimulus(1'b1, 11'(i), 8'h00, 9'(i % 512));
    checkOutput("resetHold", doutb, 32'h0);
    wea = 1'b0;
    reset = 1'b0;
    @(negedge clkin);

    $display("[TB] byte-lane mapping");
    applyStimulus(1'b1, 11'd0, 8'h11, 9'd0);
    applyStimulus(1'b1, 11'd1, 8'h22, 9'd0);
    applyStimulus(1'b1, 11'd2, 8'h33, 9'd0);
    applyStimulus(1'b1, 11'd3, 8'h44, 9'd0);
    applyStimulus(1'b0, 11'd0, 8'h00, 9'd0);
    checkOutput("laneMap", doutb, 32'h44332211);

    $display("[TB] top-of-memory boundary");
    applyStimulus(1'b1, 11'd2047, 8'hAA, 9'd0);
    applyStimulus(1'b1, 11'd2044, 8'h55, 9'd0);
    applyStimulus(1'b0, 11'd0, 8'h00, 9'd511);
    checkOutput("topWord", doutb, 32'hAA000055);

    $display("[TB] partial write");
    applyStimulus(1'b1, 11'd20, 8'hEF, 9'd0);
    applyStimulus(1'b1, 11'd21, 8'hBE, 9'd0);
    applyStimulus(1'b1, 11'd22, 8'hAD, 9'd0);
    applyStimulus(1'b1, 11'd23, 8'hDE, 9'd5);
    checkOutput("preload", doutb, 32'h00AD_BEEF);
    applyStimulus(1'b1, 11'd22, 8'h00, 9'd5);
    checkOutput("preloadFull", doutb, 32'hDEADBEEF);
    applyStimulus(1'b0, 11'd0, 8'h00, 9'd5);
    checkOutput("partial", doutb, 32'hDE00BEEF);

    $display("[TB] read-first collision");
    applyStimulus(1'b1, 11'd28, 8'h99, 9'd7);
    checkOutput("collideOld", doutb, 32'h00000000);
    applyStimulus(1'b0, 11'd0, 8'h00, 9'd7);
    checkOutput("collideNew", doutb, 32'h00000099);

    $display("[TB] asynchronous reset");
    applyStimulus(1'b0, 11'd0, 8'h00, 9'd0);
    checkOutput("preReset", doutb, 32'h44332211);
    #2 reset = 1'b1;
    #1 checkOutput("asyncClear", doutb, 32'h0);
    @(negedge clkin);
    applyStimulus(1'b1, 11'd0, 8'h77, 9'd0);
    checkOutput("resetWrite", doutb, 32'h0);
    wea = 1'b0;
    reset = 1'b0;
    applyStimulus(1'b0, 11'd0, 8'h00, 9'd0);
    checkOutput("postReset", doutb, 32'h44332277);

    $display("[TB] streaming sweep");
    for (int i = 0; i < 2048; i++)
      applyStimulus(1'b1, 11'(i), 8'((i / 4) + (i % 4)), 9'd0);
    for (int k = 0; k <= 512; k++) begin
      int w;
      logic [7:0] b0;
      w  = k % 512;
      b0 = 8'(w);
      applyStimulus(1'b0, 11'd0, 8'h00, 9'(w));
      checkOutput("stream", doutb, {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
    end

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      ra = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) == 0) rb = ra[10:2];
      else rb = 9'($urandom_range(0, 511));
      applyStimulus(1'($urandom_range(0, 1)), ra, 8'($urandom), rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
